axi_rd_channel_mo: RTL
======================

Name: axi_rd_channel_mo

Overview:
- Parametrised successor to the single-transaction read channel of the SRAM-to-AXI bridge.
- Serves NUM_PORTS SRAM-like read masters (port 0 = inst, port 1 = data by convention) onto one AXI AR/R pair.
- Supports up to MAX_OUTSTANDING in-flight reads per port; the AXI ID equals the port index.
- Routes R beats back to the originating port by rid, with per-port in-order return.

Parameters:
NUM_PORTS, 2, number of SRAM-like read ports (1..16)
MAX_OUTSTANDING, 4, max in-flight reads per port (1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sram_req  in  NUM_PORTS  per-port request
sram_wr  in  NUM_PORTS  per-port write flag; request is ignored here when 1
sram_size  in  2*NUM_PORTS  per-port size, log2 bytes
sram_addr  in  ADDR_W*NUM_PORTS  per-port address
sram_addr_ok  out  NUM_PORTS  request accepted this cycle
sram_data_ok  out  NUM_PORTS  one-cycle read-data-valid pulse
sram_rdata  out  DATA_W*NUM_PORTS  per-port read data, held until next data_ok for that port
rd_err  out  1  one-cycle pulse: accepted beat had rresp!=0, or rid had nothing outstanding
arid  out  4  = granted port index
araddr  out  ADDR_W  read address
arlen  out  8  constant 0
arsize  out  3  {1'b0, size}
arburst  out  2  constant 2'b01 (INCR)
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  response ID
rdata  in  DATA_W  response data
rresp  in  2  response status
rlast  in  1  ignored (arlen=0)
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset values: arvalid=0; arid/araddr/arsize=0; rready=0; sram_addr_ok=0; sram_data_ok=0; sram_rdata=0; rd_err=0; all outstanding counters=0.
- Eligible[p] = sram_req[p] & ~sram_wr[p] & (cnt[p] < MAX_OUTSTANDING).
- Grant: fixed priority, highest eligible index wins (data over inst).
- AR slot free = ~arvalid | (arvalid & arready).
- sram_addr_ok[p] is combinational: 1 iff slot free and p is granted; at most one bit set per cycle.
- On sram_addr_ok[p], the next edge loads arid=p, araddr, arsize, sets arvalid=1, and increments cnt[p].
- No new grant while slot busy: arvalid=1 and arready=0 holds all AR fields stable.
- Back-to-back: an AR handshake plus a new grant in the same cycle reloads the slot; arvalid stays 1.
- rready = 1 on every cycle after reset is released (the bridge always sinks).
- Beat accepted when rvalid & rready:
  - rid < NUM_PORTS and cnt[rid] > 0: next cycle sram_data_ok[rid]=1 and sram_rdata[rid]=rdata; cnt[rid] decrements on the accept edge.
  - Otherwise the beat is dropped with no data_ok, and rd_err pulses next cycle.
  - rresp != 0: data is still delivered and rd_err also pulses.
- Simultaneous increment and decrement on the same port leaves cnt unchanged.
- Latency: sram_addr_ok to arvalid is 1 cycle; R handshake to data_ok is 1 cycle.
- Ordering: per-port order is guaranteed by AXI same-ID ordering. Different ports may return interleaved.
- Full: cnt[p]==MAX_OUTSTANDING masks port p; a lower-priority port may then be granted.
- Reset mid-operation: all state cleared. Late R beats arrive with cnt=0, so they are dropped and flagged on rd_err without corrupting state.
- Counters are $clog2(MAX_OUTSTANDING+1) bits wide and never wrap.

Decomposition:
- Shared package axi_bridge_pkg holds: AXI_BURST_INCR=2'b01, AXI_LEN_SINGLE=8'd0, AXI_RESP_OKAY=2'b00, and the ID width constant AXI_ID_W=4 (shared with the write channel).
- One sub-module, rd_outstanding_ctr, instantiated per port:
  - inputs inc, dec, clk, reset;
  - outputs full and nonzero.

Test Plan:
- Single read: port0 req addr 0x1000 size 2, arready=1 -> addr_ok[0] same cycle; next cycle arvalid=1, arid=0, araddr=0x1000, arsize=3'b010; rvalid with rid=0, rdata=0xDEADBEEF -> data_ok[0] one cycle later with that data.
- Priority: ports 0 and 1 both request in the same cycle -> addr_ok=2'b10, arid=1 first; port 0 is granted after the slot frees.
- Outstanding limit: port1 issues 4 reads with rvalid held 0 -> 5th request gets addr_ok[1]=0; port 0 is still granted; one rid=1 beat returns -> port 1 is accepted again the following cycle.
- Backpressure: arready=0 for 3 cycles -> arvalid, araddr, and arid are stable; no addr_ok is given; handshake on cycle 4.
- Interleaved return: outstanding rid 0 then rid 1; R returns rid=1 (0x11), then rid=0 (0x22) -> data_ok[1] carries 0x11, then data_ok[0] carries 0x22; sram_rdata[1] still holds 0x11.
- Reset mid-flight: 2 reads pending, reset, then an rid=0 beat arrives -> no data_ok, rd_err=1 for one cycle, counters remain 0.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Constants shared by the SRAM-to-AXI bridge read and write channels.
package axi_bridge_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = 8'd0;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

    // SRAM size is log2(bytes) in two bits; AXI carries it in three.
    function automatic logic [AXI_SIZE_W-1:0] axi_size(input logic [1:0] log2_bytes);
        return {1'b0, log2_bytes};
    endfunction

endpackage

// File: rtl/rd_outstanding_ctr.sv
// Per-port count of reads issued on AR whose R beat has not yet come back.
module rd_outstanding_ctr #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             do_inc;
    logic             do_dec;

    // Saturating guards keep the count from wrapping even on misuse.
    always_comb begin
        do_inc   = inc & (cnt != CNT_MAX);
        do_dec   = dec & (cnt != '0);
        cnt_next = cnt;
        if (do_inc && !do_dec) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (do_dec && !do_inc) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they track cnt exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            full    <= 1'b0;
            nonzero <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            full    <= (cnt_next == CNT_MAX);
            nonzero <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/axi_rd_channel_mo.sv
// Multi-port, multi-outstanding AXI read channel: SRAM-like read masters onto one AR/R pair,
// AXI ID = port index, R beats routed back by rid.
module axi_rd_channel_mo
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_PORTS-1:0]          sram_req,
    input  logic [NUM_PORTS-1:0]          sram_wr,
    input  logic [2*NUM_PORTS-1:0]        sram_size,
    input  logic [ADDR_W*NUM_PORTS-1:0]   sram_addr,
    output logic [NUM_PORTS-1:0]          sram_addr_ok,
    output logic [NUM_PORTS-1:0]          sram_data_ok,
    output logic [DATA_W*NUM_PORTS-1:0]   sram_rdata,
    output logic                          rd_err,

    output logic [AXI_ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [AXI_LEN_W-1:0]          arlen,
    output logic [AXI_SIZE_W-1:0]         arsize,
    output logic [AXI_BURST_W-1:0]        arburst,
    output logic [1:0]                    arlock,
    output logic [3:0]                    arcache,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,

    input  logic [AXI_ID_W-1:0]           rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [AXI_RESP_W-1:0]         rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] nonzero;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] dec;

    logic                 grant_vld;
    logic [AXI_ID_W-1:0]  grant_id;
    logic [ADDR_W-1:0]    grant_addr;
    logic [1:0]           grant_size;

    logic                 slot_free;
    logic                 beat;
    logic                 rid_ok;
    logic                 bad_resp;
    logic                 unused_rlast;

    assign arlen        = AXI_LEN_SINGLE;
    assign arburst      = AXI_BURST_INCR;
    assign arlock       = 2'b00;
    assign arcache      = 4'b0000;
    assign arprot       = 3'b000;
    assign unused_rlast = rlast;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ctr
        rd_outstanding_ctr #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .inc     (sram_addr_ok[p]),
            .dec     (dec[p]),
            .full    (full[p]),
            .nonzero (nonzero[p])
        );
    end

    // Fixed priority: later loop iterations overwrite, so the highest eligible index wins.
    always_comb begin
        eligible   = sram_req & ~sram_wr & ~full;
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_addr = '0;
        grant_size = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (eligible[p]) begin
                grant_vld  = 1'b1;
                grant_id   = AXI_ID_W'(p);
                grant_addr = sram_addr[p*ADDR_W +: ADDR_W];
                grant_size = sram_size[2*p +: 2];
            end
        end
    end

    assign slot_free = ~arvalid | arready;

    always_comb begin
        sram_addr_ok = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            sram_addr_ok[p] = slot_free & grant_vld & (grant_id == AXI_ID_W'(p));
        end
    end

    // A beat only retires a read if its port actually has one in flight.
    always_comb begin
        beat = rvalid & rready;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            hit[p] = (rid == AXI_ID_W'(p));
        end
        dec      = {NUM_PORTS{beat}} & hit & nonzero;
        rid_ok   = |dec;
        bad_resp = (rresp != AXI_RESP_OKAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid      <= 1'b0;
            arid         <= '0;
            araddr       <= '0;
            arsize       <= '0;
            rready       <= 1'b0;
            sram_data_ok <= '0;
            sram_rdata   <= '0;
            rd_err       <= 1'b0;
        end else begin
            rready <= 1'b1;
            if (slot_free) begin
                arvalid <= grant_vld;
                if (grant_vld) begin
                    arid   <= grant_id;
                    araddr <= grant_addr;
                    arsize <= axi_size(grant_size);
                end
            end
            sram_data_ok <= dec;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (dec[p]) begin
                    sram_rdata[p*DATA_W +: DATA_W] <= rdata;
                end
            end
            rd_err <= beat & (~rid_ok | bad_resp);
        end
    end

endmodule
